mmio_uart_tx: RTL
=================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries; power of two, 2..64.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port mmio_wea  input  1  one-cycle write strobe from the core memory stage.
REQ-006 SHALL have port mmio_dat  input  32  write data; only bits [7:0] are transmitted, [31:8] ignored.
REQ-007 SHALL have port tx  output  1  serial line, 8N1, idle high.
REQ-008 SHALL have port mmio_read  output  1  one-cycle pulse each time a byte leaves the FIFO into the shifter.
REQ-009 SHALL have port fifo_full  output  1  high when the FIFO holds FIFO_DEPTH bytes.
REQ-010 SHALL have port tx_busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-011 SHALL push mmio_dat[7:0] into the FIFO on a clk edge where mmio_wea=1 and (fifo_full=0 or a pop occurs in the same cycle).
REQ-012 SHALL silently drop a write when mmio_wea=1, fifo_full=1 and no pop in that cycle; FIFO contents and count stay unchanged.
REQ-013 SHALL keep an occupancy count of width log2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, all outputs registered.
REQ-015 IDLE: tx=1; if FIFO non-empty, pop head into an 8-bit shift register, pulse mmio_read for that single cycle, go to START.
REQ-016 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-017 DATA: tx=shift[0] (LSB first) for CLKS_PER_BIT cycles per bit; shift right after each bit; after bit index 7 go to STOP.
REQ-018 STOP: tx=1 for exactly CLKS_PER_BIT cycles; at the end, if FIFO non-empty, pop, pulse mmio_read and go directly to START (no idle gap), else go to IDLE.
REQ-019 SHALL make a full frame exactly 10*CLKS_PER_BIT cycles, with tx falling the cycle after the pop edge.
REQ-020 SHALL make the baud counter count 0..CLKS_PER_BIT-1 and clear on every state or bit transition.
REQ-021 A write arriving while the FSM is in IDLE with an empty FIFO SHALL be popped on the following edge (2-cycle write-to-start latency).
REQ-022 Simultaneous push and pop with the FIFO full SHALL leave count at FIFO_DEPTH and keep fifo_full=1.
REQ-023 mmio_read SHALL never be high for two consecutive cycles.

Reset
REQ-024 On Rst=1, immediately and regardless of clk: tx=1, mmio_read=0, fifo_full=0, tx_busy=0, FSM=IDLE, counters, pointers and count=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; queued bytes are discarded and not sent after release.
REQ-026 The first write accepted SHALL be on the first clk edge with Rst=0.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-027 Single byte: write 0x000000A5 once -> mmio_read pulse 1 cycle later; tx samples at bit centres 0,1,0,1,0,0,1,0,1,1; tx_busy low after 40 cycles of frame.
REQ-028 Back-to-back: write 0x31,0x32,0x33 on consecutive cycles -> three contiguous frames, 120 cycles of tx activity, no high gap beyond stop bits, three mmio_read pulses 40 cycles apart.
REQ-029 Overflow: while first frame is in flight, write 10 bytes 0x00..0x09 -> bytes 0x00..0x07 accepted, fifo_full=1, 0x08/0x09 dropped; 9 frames total transmitted (first byte plus 8).
REQ-030 Full with simultaneous pop: FIFO full, write 0x5A on the pop cycle at end of STOP -> 0x5A accepted and transmitted last.
REQ-031 Reset mid-frame: assert Rst during DATA bit 3 with 4 bytes queued -> tx=1 asynchronously, no further frames or mmio_read pulses after release until a new write.
REQ-032 Upper bits ignored: write 0xFFFFFF00 -> transmitted byte 0x00.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a small byte FIFO fed by single-cycle
// core writes, drained by a registered-output serialiser.
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        mmio_wea,
    input  logic [31:0] mmio_dat,
    output logic        tx,
    output logic        mmio_read,
    output logic        fifo_full,
    output logic        tx_busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CntLast = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    count_q, count_d;
    logic           tx_q, tx_d, read_q, busy_q;
    logic           pop, push, empty, full, bit_end;
    logic           unused_dat;

    assign unused_dat = ^mmio_dat[31:8];

    assign empty   = (count_q == '0);
    // Count never exceeds FIFO_DEPTH, so its MSB alone flags full.
    assign full    = count_q[AW];
    assign bit_end = (cnt_q == CntLast);
    assign push    = mmio_wea && (!full || pop);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_q];
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_q];
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level follows the next state so tx changes on the same edge as the FSM.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            tx_q    <= 1'b1;
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            wr_q    <= push ? wr_q + AW'(1) : wr_q;
            rd_q    <= pop ? rd_q + AW'(1) : rd_q;
            count_q <= count_d;
            tx_q    <= tx_d;
            read_q  <= pop;
            busy_q  <= (state_d != StIdle) || (count_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= mmio_dat[7:0];
        end
    end

    assign tx        = tx_q;
    assign mmio_read = read_q;
    assign fifo_full = full;
    assign tx_busy   = busy_q;

endmodule
